// File: rtl/div_pkg.sv
// Shared constants and FSM state type for the divider-result binary-to-BCD converter.
package div_pkg;

  localparam int unsigned WIDTH   = 16;
  localparam int unsigned DIGITS  = 5;
  localparam int unsigned CNT_MAX = 16;
  localparam int unsigned BCD_W   = DIGITS * 4;
  localparam int unsigned CNT_W   = 5;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

endpackage

// File: rtl/bcd_add3_adjust.sv
// Per-digit double-dabble correction: each BCD digit >= 5 gets +3, no inter-digit carry.
module bcd_add3_adjust #(
  parameter int unsigned DIGITS = div_pkg::DIGITS
) (
  input  logic [DIGITS*4-1:0] i_bcd,
  output logic [DIGITS*4-1:0] o_bcd
);

  for (genvar g_d = 0; g_d < DIGITS; g_d++) begin : g_digit
    logic [3:0] w_dig;
    assign w_dig              = i_bcd[g_d*4 +: 4];
    assign o_bcd[g_d*4 +: 4]  = (w_dig >= 4'd5) ? w_dig + 4'd3 : w_dig;
  end

endmodule

// File: rtl/div_result_bcd.sv
// Converts a 16/8 divider quotient and remainder to packed BCD with a shared
// 16-step shift-and-add-3 sequence; outputs are held in registers until handshaked.
module div_result_bcd #(
  parameter int unsigned WIDTH  = div_pkg::WIDTH,
  parameter int unsigned DIGITS = div_pkg::DIGITS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    result,
  input  logic [WIDTH-1:0]    odd,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DIGITS*4-1:0] bcd_q,
  output logic [DIGITS*4-1:0] bcd_r
);

  import div_pkg::*;

  localparam int unsigned BW = DIGITS * 4;
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(CNT_MAX);

  state_e r_state, w_state_d;

  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_sh_q, r_sh_r;
  logic [BW-1:0]    r_acc_q, r_acc_r;
  logic [BW-1:0]    r_bcd_q, r_bcd_r;

  logic [BW-1:0]       w_adj_q, w_adj_r;
  logic [BW+WIDTH-1:0] w_cat_q, w_cat_r;
  logic                w_shift_done;

  bcd_add3_adjust #(
    .DIGITS (DIGITS)
  ) u_adj_q (
    .i_bcd (r_acc_q),
    .o_bcd (w_adj_q)
  );

  bcd_add3_adjust #(
    .DIGITS (DIGITS)
  ) u_adj_r (
    .i_bcd (r_acc_r),
    .o_bcd (w_adj_r)
  );

  // Shift-register MSB moves into accumulator bit 0 after the +3 correction.
  assign w_cat_q      = {w_adj_q, r_sh_q} << 1;
  assign w_cat_r      = {w_adj_r, r_sh_r} << 1;
  assign w_shift_done = (r_cnt == CntLast);

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (in_valid)     w_state_d = StShift;
      StShift: if (w_shift_done) w_state_d = StDone;
      StDone:  if (out_ready)    w_state_d = StIdle;
      default:                   w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_sh_q  <= '0;
      r_sh_r  <= '0;
      r_acc_q <= '0;
      r_acc_r <= '0;
      r_bcd_q <= '0;
      r_bcd_r <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (in_valid) begin
            r_sh_q  <= result;
            r_sh_r  <= odd;
            r_acc_q <= '0;
            r_acc_r <= '0;
            r_cnt   <= '0;
          end
        end
        StShift: begin
          if (!w_shift_done) begin
            r_acc_q <= w_cat_q[BW+WIDTH-1:WIDTH];
            r_sh_q  <= w_cat_q[WIDTH-1:0];
            r_acc_r <= w_cat_r[BW+WIDTH-1:WIDTH];
            r_sh_r  <= w_cat_r[WIDTH-1:0];
            r_cnt   <= r_cnt + 1'b1;
          end else begin
            r_bcd_q <= r_acc_q;
            r_bcd_r <= r_acc_r;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == StIdle);
  assign out_valid = (r_state == StDone);
  assign bcd_q     = r_bcd_q;
  assign bcd_r     = r_bcd_r;

endmodule
